strip_trigger_rx: RTL and testbench
===================================

# strip_trigger_rx

Receiver/decoder for the strip trigger link: recovers the 13-bit band/phi word and 12-bit BCID from the DDR trigger lanes (en, d0, d1), checks framing, and presents one decoded trigger per frame. It sits behind the board's input IDDR primitives. Those primitives deliver each lane as an even/odd bit pair per clk_slow cycle, so the block runs entirely in the clk_slow domain.

## Interface
- CNT_W, 16, width of frame and error counters
- clk_slow  input  1  link clock; one even/odd bit pair per lane per cycle
- reset  input  1  asynchronous, active-high
- en_even, en_odd  input  1 each  enable lane, first/second bit-time of cycle
- d0_even, d0_odd  input  1 each  band/phi lane
- d1_even, d1_odd  input  1 each  BCID lane
- cnt_clr  input  1  synchronous clear of both counters
- trig_valid  output  1  one-cycle pulse, decoded fields valid
- trig_bcid  output  12  decoded BCID
- phi_id  output  5  decoded phi id
- bandid  output  8  decoded band id
- frame_err  output  1  one-cycle pulse on malformed frame
- busy  output  1  high while a frame is being received
- frame_cnt  output  CNT_W  good frames, wraps
- err_cnt  output  CNT_W  errored frames, saturates at all-ones

## Operation
- Frame is 7 cycles, k=0..6, MSB first.
  - Cycle k: d0_even=W0[12-2k], d0_odd=W0[11-2k], d1_even=W1[12-2k], d1_odd=W1[11-2k].
  - Cycle 6: both odd bits are padding 0.
- W0={phi_id[4:0],bandid[7:0]}; W1={bcid[11:0],1'b0}.
- en_even is 1 for cycles 0..6. en_odd is 1 for cycles 0..5 and 0 at cycle 6.
- States IDLE, RECV:
  - IDLE -> RECV when armed and en_even=1; that cycle is k=0.
  - RECV counts k=1..6, then returns to IDLE.
- armed: cleared by reset and on entry to RECV; set by any IDLE cycle with en_even=0. A stuck-high or back-to-back en without a gap does not start a frame.
- busy = (state==RECV) or start condition this cycle.
- Good frame: trig_valid=1 for one cycle; fields updated; frame_cnt++.
- Bad frame: frame_err=1 for one cycle; fields hold; err_cnt++ (saturating). trig_valid and frame_err are never both high.
- cnt_clr and an increment in the same cycle: clear wins, counter reads 0.

## Timing
- Reset values: trig_valid=0, frame_err=0, busy=0, all fields 0, counters 0, state IDLE, armed=0.
- Latency: cycle 6 is sampled at edge E6. trig_valid or frame_err is high in the cycle after E6. Fields are stable from E6 until the next good frame.
- Minimum frame spacing is 8 cycles (7 frame cycles plus 1 en-low gap).
- Reset mid-frame discards the partial frame with no pulse. The next frame requires an en-low cycle first.

## Configuration
- STRIP_TRIG_RX_CHECK_EN defined:
  - Abort when en_even=0 or en_odd=0 at k=1..5: frame_err pulses in the cycle after the failing edge, state goes to IDLE, armed=0.
  - Flag error when any of these is 1 at k=6: en_odd, d0_odd, d1_odd, d1_even.
- STRIP_TRIG_RX_CHECK_EN undefined:
  - No checks; every started frame completes after 7 cycles with trig_valid.
  - frame_err is tied 0 and err_cnt stays 0.

## Structure
- Package strip_trig_pkg holds:
  - FRAME_LEN=7, W0_BITS=13, W1_BITS=13
  - field widths: BCID_W=12, PHI_W=5, BAND_W=8
  - state enum {IDLE, RECV}
- Sub-module strip_trig_lane_deser: shifts 2 bits per cycle into a 14-bit word (the last bit is padding). It is instantiated for d0 and d1.

## Test plan
- Frame phi=5'h15, band=8'hA3, bcid=12'hABC: W0=13'b1010110100011, W1=13'b1010101111000. Expect trig_valid once, phi_id=15, bandid=A3, trig_bcid=ABC, frame_cnt=1.
- Two frames with an 8-cycle spacing (bcid 12'h001, then 12'hFFF): expect two pulses with the matching values. With a 7-cycle spacing (no gap), the second frame is ignored.
- en stuck high for 20 cycles after one good frame: expect exactly one trig_valid and no more.
- With CHECK_EN, en_odd=0 at k=3: expect frame_err the cycle after that edge, err_cnt=1, fields unchanged. At k=6 en_odd=1: expect frame_err and no trig_valid.
- Reset asserted at k=4 of a frame: expect all outputs 0 and no pulse. en low for 1 cycle, then a good frame: expect normal decode.
- err_cnt preloaded to all-ones by forcing errors: expect it to stay all-ones. Assert cnt_clr in the same cycle as a good frame: expect frame_cnt=0 afterwards.

Source files
------------

// File: rtl/strip_trig_pkg.sv
// Shared constants, state type and lane shift helper for the strip trigger receiver.
package strip_trig_pkg;

  localparam int FRAME_LEN = 7;
  localparam int W0_BITS   = 13;
  localparam int W1_BITS   = 13;
  localparam int BCID_W    = 12;
  localparam int PHI_W     = 5;
  localparam int BAND_W    = 8;
  // Each lane delivers two bits per cycle, so the padded word is one bit wider than the payload.
  localparam int DESER_W   = ((W0_BITS > W1_BITS) ? W0_BITS : W1_BITS) + 1;
  localparam logic [2:0] LAST_K = 3'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  function automatic logic [DESER_W-1:0] shift_pair(input logic [DESER_W-1:0] word,
                                                     input logic bit_even,
                                                     input logic bit_odd);
    return {word[DESER_W-3:0], bit_even, bit_odd};
  endfunction

endpackage

// File: rtl/strip_trig_lane_deser.sv
// One-lane deserializer: shifts the even/odd bit pair MSB-first into a padded word.
module strip_trig_lane_deser
  import strip_trig_pkg::*;
(
  input  logic               clk_slow,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               bit_even,
  input  logic               bit_odd,
  output logic [DESER_W-1:0] word_next
);

  logic [DESER_W-1:0] word_r;

  // word_next already contains this cycle's pair so the last cycle can be decoded at its own edge
  assign word_next = shift_pair(word_r, bit_even, bit_odd);

  // Shift register, advances only while a frame is being received
  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      word_r <= {DESER_W{1'b0}};
    end else if (shift_en) begin
      word_r <= word_next;
    end else begin
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/strip_trigger_rx.sv
// Strip trigger link receiver: frames the DDR lanes, decodes band/phi/BCID and counts frames.
// Build option: define STRIP_TRIG_RX_CHECK_EN to enable framing checks and frame_err reporting.
module strip_trigger_rx
  import strip_trig_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk_slow,
  input  logic              reset,
  input  logic              en_even,
  input  logic              en_odd,
  input  logic              d0_even,
  input  logic              d0_odd,
  input  logic              d1_even,
  input  logic              d1_odd,
  input  logic              cnt_clr,
  output logic              trig_valid,
  output logic [BCID_W-1:0] trig_bcid,
  output logic [PHI_W-1:0]  phi_id,
  output logic [BAND_W-1:0] bandid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  rx_state_e          state_r, state_next_s;
  logic [2:0]         k_r, k_next_s;
  logic               armed_r, armed_next_s;
  logic               start_s, last_s, abort_s, bad_last_s, good_s, bad_s, busy_s;
  logic [DESER_W-1:0] w0_next_s, w1_next_s;
  logic               trig_valid_r, frame_err_r;
  logic [BCID_W-1:0]  bcid_r;
  logic [PHI_W-1:0]   phi_r;
  logic [BAND_W-1:0]  band_r;
  logic [CNT_W-1:0]   frame_cnt_r, err_cnt_r;

  assign start_s = (state_r == IDLE) && armed_r && en_even;
  assign last_s  = (state_r == RECV) && (k_r == LAST_K);
  assign busy_s  = (state_r == RECV) || start_s;

`ifdef STRIP_TRIG_RX_CHECK_EN
  assign abort_s    = (state_r == RECV) && (k_r != LAST_K) && !(en_even && en_odd);
  assign bad_last_s = last_s && (en_odd | w0_next_s[0] | w1_next_s[1] | w1_next_s[0]);
`else
  logic unused_s;
  assign abort_s    = 1'b0;
  assign bad_last_s = 1'b0;
  assign unused_s   = ^{en_odd, w0_next_s[0], w1_next_s[1:0]};
`endif

  assign good_s = last_s && !bad_last_s;
  assign bad_s  = abort_s || bad_last_s;

  strip_trig_lane_deser u_deser_d0 (
    .clk_slow  (clk_slow),
    .reset     (reset),
    .shift_en  (busy_s),
    .bit_even  (d0_even),
    .bit_odd   (d0_odd),
    .word_next (w0_next_s)
  );

  strip_trig_lane_deser u_deser_d1 (
    .clk_slow  (clk_slow),
    .reset     (reset),
    .shift_en  (busy_s),
    .bit_even  (d1_even),
    .bit_odd   (d1_odd),
    .word_next (w1_next_s)
  );

  // Next state: a frame starts only after an en-low IDLE cycle has re-armed the receiver
  always_comb begin
    state_next_s = state_r;
    k_next_s     = k_r;
    armed_next_s = armed_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_next_s = RECV;
          k_next_s     = 3'd1;
          armed_next_s = 1'b0;
        end else if (!en_even) begin
          armed_next_s = 1'b1;
        end else begin
          armed_next_s = armed_r;
        end
      end
      RECV: begin
        if (last_s || abort_s) begin
          state_next_s = IDLE;
          k_next_s     = 3'd0;
        end else begin
          k_next_s = k_r + 3'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        k_next_s     = 3'd0;
        armed_next_s = 1'b0;
      end
    endcase
  end

  // Frame sequencer state
  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      k_r     <= 3'd0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      k_r     <= k_next_s;
      armed_r <= armed_next_s;
    end
  end

  // Result pulses and decoded fields; fields only move on a good frame
  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      trig_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      bcid_r       <= {BCID_W{1'b0}};
      phi_r        <= {PHI_W{1'b0}};
      band_r       <= {BAND_W{1'b0}};
    end else begin
      trig_valid_r <= good_s;
      frame_err_r  <= bad_s;
      if (good_s) begin
        phi_r  <= w0_next_s[DESER_W-1 -: PHI_W];
        band_r <= w0_next_s[DESER_W-1-PHI_W -: BAND_W];
        bcid_r <= w1_next_s[DESER_W-1 -: BCID_W];
      end
    end
  end

  // Frame counter wraps, error counter saturates; clear has priority over counting
  always_ff @(posedge clk_slow or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      frame_cnt_r <= {CNT_W{1'b0}};
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (good_s) begin
        frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bad_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign trig_valid = trig_valid_r;
  assign frame_err  = frame_err_r;
  assign trig_bcid  = bcid_r;
  assign phi_id     = phi_r;
  assign bandid     = band_r;
  assign busy       = busy_s;
  assign frame_cnt  = frame_cnt_r;
  assign err_cnt    = err_cnt_r;

endmodule

// File: tb/tb_strip_trigger_rx.sv
// Self-checking bench for strip_trigger_rx: per-cycle model compare plus pinned literal checks.
// Honours STRIP_TRIG_RX_CHECK_EN to match the DUT build.
module tb_strip_trigger_rx;

`ifdef STRIP_TRIG_RX_CHECK_EN
  localparam int CW    = 4;
  localparam bit CHECK = 1'b1;
`else
  localparam int CW    = 16;
  localparam bit CHECK = 1'b0;
`endif

  logic          clk_slow, reset;
  logic          en_even, en_odd, d0_even, d0_odd, d1_even, d1_odd, cnt_clr;
  logic          trig_valid, frame_err, busy;
  logic [11:0]   trig_bcid;
  logic [4:0]    phi_id;
  logic [7:0]    bandid;
  logic [CW-1:0] frame_cnt, err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;

  // model state: position within frame (-1 = none), gap seen, accumulated lane values
  int m_pos, m_acc0, m_acc1, m_fcnt, m_ecnt;
  bit m_gap, m_valid, m_err;
  int m_phi, m_band, m_bcid;

  strip_trigger_rx #(.CNT_W(CW)) dut (
    .clk_slow(clk_slow), .reset(reset),
    .en_even(en_even), .en_odd(en_odd),
    .d0_even(d0_even), .d0_odd(d0_odd),
    .d1_even(d1_even), .d1_odd(d1_odd),
    .cnt_clr(cnt_clr),
    .trig_valid(trig_valid), .trig_bcid(trig_bcid),
    .phi_id(phi_id), .bandid(bandid),
    .frame_err(frame_err), .busy(busy),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_gap = 1'b0; m_acc0 = 0; m_acc1 = 0;
    m_valid = 1'b0; m_err = 1'b0; m_fcnt = 0; m_ecnt = 0;
    m_phi = 0; m_band = 0; m_bcid = 0;
  endtask

  // advance the model by the cycle whose inputs are currently applied
  task automatic model_step();
    int nv, ne;
    nv = 0; ne = 0;
    if (m_pos < 0) begin
      if (en_even && m_gap) begin
        m_pos = 0; m_gap = 1'b0;
        m_acc0 = 2 * d0_even + d0_odd;
        m_acc1 = 2 * d1_even + d1_odd;
      end else if (!en_even) begin
        m_gap = 1'b1;
      end
    end else begin
      m_pos++;
      m_acc0 = m_acc0 * 4 + 2 * d0_even + d0_odd;
      m_acc1 = m_acc1 * 4 + 2 * d1_even + d1_odd;
      if (CHECK && m_pos <= 5 && !(en_even && en_odd)) begin
        ne = 1; m_pos = -1;
      end else if (m_pos == 6) begin
        if (CHECK && (en_odd || d0_odd || d1_odd || d1_even)) begin
          ne = 1;
        end else begin
          nv = 1;
          m_phi  = (m_acc0 / 2) / 256;
          m_band = (m_acc0 / 2) % 256;
          m_bcid = (m_acc1 / 2) / 2;
        end
        m_pos = -1;
      end
    end
    m_valid = (nv != 0);
    m_err   = (ne != 0);
    if (cnt_clr) begin
      m_fcnt = 0; m_ecnt = 0;
    end else begin
      m_fcnt = (m_fcnt + nv) % (1 << CW);
      if (m_ecnt + ne <= (1 << CW) - 1) m_ecnt = m_ecnt + ne;
    end
  endtask

  // compare process: outputs are stable at the falling edge
  initial begin
    model_reset();
    forever begin
      @(negedge clk_slow);
      if (reset) model_reset();
      chk("trig_valid", trig_valid, m_valid);
      chk("frame_err", frame_err, m_err);
      chk("busy", busy, (m_pos >= 0) || (m_gap && en_even && !reset));
      chk("trig_bcid", trig_bcid, m_bcid);
      chk("phi_id", phi_id, m_phi);
      chk("bandid", bandid, m_band);
      chk("frame_cnt", frame_cnt, m_fcnt);
      chk("err_cnt", err_cnt, m_ecnt);
      if (trig_valid === 1'b1) n_valid++;
      if (frame_err === 1'b1) n_err++;
      if (!reset) model_step();
    end
  end

  task automatic drive(input logic ee, input logic eo, input logic a0, input logic b0,
                       input logic a1, input logic b1);
    en_even = ee; en_odd = eo; d0_even = a0; d0_odd = b0; d1_even = a1; d1_odd = b1;
    @(posedge clk_slow);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [4:0] phi, input logic [7:0] band, input logic [11:0] bcid,
                       input int bad_k, input bit odd6, input bit clr6, input int stop_k);
    logic [12:0] w0, w1;
    w0 = {phi, band};
    w1 = {bcid, 1'b0};
    for (int k = 0; k < stop_k; k++) begin
      logic eo, b0, b1;
      eo = (k < 6); b0 = 1'b0; b1 = 1'b0;
      if (k < 6) begin
        b0 = w0[11-2*k];
        b1 = w1[11-2*k];
      end
      if (k == bad_k) eo = 1'b0;
      if (k == 6 && odd6) eo = 1'b1;
      cnt_clr = clr6 && (k == 6);
      drive(1'b1, eo, w0[12-2*k], b0, w1[12-2*k], b1);
    end
    cnt_clr = 1'b0;
  endtask

  task automatic good(input logic [4:0] phi, input logic [7:0] band, input logic [11:0] bcid);
    frame(phi, band, bcid, -1, 1'b0, 1'b0, 7);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; cnt_clr = 1'b0;
    en_even = 1'b0; en_odd = 1'b0; d0_even = 1'b0; d0_odd = 1'b0; d1_even = 1'b0; d1_odd = 1'b0;
    idle(2);
    chk("rst_valid", trig_valid, 32'h0);
    chk("rst_cnt", frame_cnt, 32'h0);
    reset = 1'b0;
    idle(2);

    // basic decode
    good(5'h15, 8'hA3, 12'hABC);
    chk("t1_pulse", trig_valid, 32'h1);
    idle(1);
    chk("t1_phi", phi_id, 32'h15);
    chk("t1_band", bandid, 32'hA3);
    chk("t1_bcid", trig_bcid, 32'hABC);
    chk("t1_cnt", frame_cnt, 32'h1);
    chk("t1_nvalid", n_valid, 32'd1);

    // 8-cycle spacing
    good(5'h0A, 8'h5C, 12'h001);
    idle(1);
    chk("t2a_bcid", trig_bcid, 32'h001);
    good(5'h1F, 8'hFF, 12'hFFF);
    idle(1);
    chk("t2b_bcid", trig_bcid, 32'hFFF);
    chk("t2b_phi", phi_id, 32'h1F);
    chk("t2_cnt", frame_cnt, 32'h3);
    chk("t2_nvalid", n_valid, 32'd3);

    // no gap: second frame ignored
    good(5'h03, 8'h11, 12'h123);
    good(5'h04, 8'h22, 12'h456);
    idle(1);
    chk("t3_bcid", trig_bcid, 32'h123);
    chk("t3_nvalid", n_valid, 32'd4);

    // en stuck high after a frame
    good(5'h06, 8'h33, 12'h789);
    repeat (20) drive(1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    idle(2);
    chk("t4_bcid", trig_bcid, 32'h789);
    chk("t4_nvalid", n_valid, 32'd5);

    // en_odd low at k=3, then en_odd high at k=6
    frame(5'h07, 8'h44, 12'h0F0, 3, 1'b0, 1'b0, 7);
    idle(1);
    frame(5'h08, 8'h55, 12'h321, -1, 1'b1, 1'b0, 7);
    idle(1);
`ifdef STRIP_TRIG_RX_CHECK_EN
    chk("t5_bcid", trig_bcid, 32'h789);
    chk("t5_nerr", n_err, 32'd2);
    chk("t5_errcnt", err_cnt, 32'h2);
    chk("t5_nvalid", n_valid, 32'd5);
`else
    chk("t5_bcid", trig_bcid, 32'h321);
    chk("t5_nerr", n_err, 32'd0);
    chk("t5_errcnt", err_cnt, 32'h0);
    chk("t5_nvalid", n_valid, 32'd7);
`endif

    // reset at k=4
    frame(5'h09, 8'h66, 12'h654, -1, 1'b0, 1'b0, 4);
    reset = 1'b1;
    #1;
    chk("t7_valid", trig_valid, 32'h0);
    chk("t7_busy", busy, 32'h0);
    chk("t7_bcid", trig_bcid, 32'h0);
    chk("t7_cnt", frame_cnt, 32'h0);
    idle(2);
    reset = 1'b0;
    idle(1);
    good(5'h0A, 8'h77, 12'h5A5);
    idle(1);
    chk("t7b_bcid", trig_bcid, 32'h5A5);
    chk("t7b_band", bandid, 32'h77);
    chk("t7b_cnt", frame_cnt, 32'h1);

    // clear coinciding with a good frame
    frame(5'h0B, 8'h88, 12'hA5A, -1, 1'b0, 1'b1, 7);
    idle(1);
    chk("t8_bcid", trig_bcid, 32'hA5A);
    chk("t8_cnt", frame_cnt, 32'h0);
    good(5'h0C, 8'h99, 12'h777);
    idle(1);
    chk("t9_cnt", frame_cnt, 32'h1);

`ifdef STRIP_TRIG_RX_CHECK_EN
    // error counter saturation
    repeat (18) begin
      frame(5'h00, 8'h00, 12'h000, 1, 1'b0, 1'b0, 7);
      idle(1);
    end
    chk("sat_errcnt", err_cnt, 32'hF);
    chk("sat_cnt", frame_cnt, 32'h1);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    idle(1);
    chk("clr_errcnt", err_cnt, 32'h0);
`else
    chk("end_errcnt", err_cnt, 32'h0);
    chk("end_nerr", n_err, 32'd0);
`endif
    idle(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
